// File: rtl/sys_pkg.sv
// -----------------------------------------------------------------------------
// sys_pkg
// Shared definitions for the UART command controller:
//   - command opcodes recognised in IDLE
//   - register-file addresses used to stage ALU operands
//   - FSM state enumeration of sys_cmd_ctrl
// -----------------------------------------------------------------------------
package sys_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;  // write: cmd, addr, data
    localparam logic [7:0] CMD_RD      = 8'hBB;  // read:  cmd, addr
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // ALU:   cmd, A, B, func
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // ALU:   cmd, func

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_FUNC,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_HI,
        S_TX_RD
    } state_t;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// sys_cmd_ctrl
// Decodes command bytes arriving from a UART receiver and drives a register
// file, an ALU and a TX FIFO.
//
// Ports:
//   CLK, RST        single clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD   received byte and its one-cycle qualifier
//   ADDRESS, WR_EN, WR_DATA, RD_EN   register-file access (strobes one cycle)
//   RD_DATA/RD_DATA_VLD  register-file read return
//   ALU_EN, ALU_FUN      ALU start strobe and function code
//   ALU_OUT/ALU_OUT_VLD  ALU result (2*DATA_WIDTH) and qualifier
//   CLK_GATE_EN          ALU clock-gate enable
//   TX_DATA, TX_PUSH, TX_FULL  TX FIFO write interface
// -----------------------------------------------------------------------------
module sys_cmd_ctrl
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]   ADDRESS,
    output logic                    WR_EN,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    RD_EN,
    input  logic [DATA_WIDTH-1:0]   RD_DATA,
    input  logic                    RD_DATA_VLD,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_PUSH,
    input  logic                    TX_FULL
);

    state_t                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic                    wr_en_q,   wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    rd_en_q,   rd_en_d;
    logic                    alu_en_q,  alu_en_d;
    logic [3:0]              alu_fun_q, alu_fun_d;
    logic [DATA_WIDTH-1:0]   rd_byte_q, rd_byte_d;
    logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;

    logic                    tx_push;
    logic [DATA_WIDTH-1:0]   tx_data;

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        alu_fun_d = alu_fun_q;
        rd_byte_d = rd_byte_q;
        alu_res_d = alu_res_q;
        tx_push   = 1'b0;
        tx_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_WR))
                        state_d = S_WR_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))
                        state_d = S_RD_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))
                        state_d = S_OP_A;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP))
                        state_d = S_FUNC;
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    state_d   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (RD_DATA_VLD) begin
                    rd_byte_d = RD_DATA;
                    state_d   = S_TX_RD;
                end
            end
            S_OP_A: begin
                if (RX_D_VLD) begin
                    address_d = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_OP_B;
                end
            end
            S_OP_B: begin
                if (RX_D_VLD) begin
                    address_d = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_FUNC;
                end
            end
            S_FUNC: begin
                if (RX_D_VLD) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = RX_P_DATA[3:0];
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    alu_res_d = ALU_OUT;
                    state_d   = S_TX_LO;
                end
            end
            // TX states: TX_DATA is presented for as long as the state is held,
            // and the push (and advance) happens only in a cycle with room.
            S_TX_LO: begin
                tx_data = alu_res_q[DATA_WIDTH-1:0];
                tx_push = !TX_FULL;
                if (!TX_FULL) state_d = S_TX_HI;
            end
            S_TX_HI: begin
                tx_data = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                tx_push = !TX_FULL;
                if (!TX_FULL) state_d = S_IDLE;
            end
            S_TX_RD: begin
                tx_data = rd_byte_q;
                tx_push = !TX_FULL;
                if (!TX_FULL) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            address_q <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            rd_byte_q <= '0;
            alu_res_q <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            alu_fun_q <= alu_fun_d;
            rd_byte_q <= rd_byte_d;
            alu_res_q <= alu_res_d;
        end
    end

    assign ADDRESS     = address_q;
    assign WR_EN       = wr_en_q;
    assign WR_DATA     = wr_data_q;
    assign RD_EN       = rd_en_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    // ALU_EN is issued in the first ALU_WAIT cycle and the result is captured
    // in the last one, so the gate window is exactly the ALU_WAIT state.
    assign CLK_GATE_EN = (state_q == S_ALU_WAIT);
    assign TX_DATA     = tx_data;
    assign TX_PUSH     = tx_push;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
module tb_sys_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_ALU = 2'd2;
    localparam logic [1:0] EV_TX  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  addr;
        logic [15:0] data;
    } evt_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic [AW-1:0] ADDRESS;
    logic          WR_EN;
    logic [DW-1:0] WR_DATA;
    logic          RD_EN;
    logic [DW-1:0] RD_DATA;
    logic          RD_DATA_VLD;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic [2*DW-1:0] ALU_OUT;
    logic          ALU_OUT_VLD;
    logic          CLK_GATE_EN;
    logic [DW-1:0] TX_DATA;
    logic          TX_PUSH;
    logic          TX_FULL;

    sys_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ADDRESS(ADDRESS), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
        .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_DATA(TX_DATA), .TX_PUSH(TX_PUSH), .TX_FULL(TX_FULL)
    );

    always #5 CLK = ~CLK;

    evt_t exp_q[$];
    evt_t obs_q[$];
    int   total  = 0;
    int   passed = 0;
    int   viol   = 0;

    function automatic evt_t mk(input logic [1:0] k, input logic [3:0] a, input logic [15:0] d);
        evt_t e;
        e.kind = k; e.addr = a; e.data = d;
        return e;
    endfunction

    // Monitor: records every strobe as an event and flags protocol violations.
    always @(negedge CLK) begin
        if ((int'(WR_EN) + int'(RD_EN) + int'(ALU_EN) + int'(TX_PUSH)) > 1) viol++;
        if (TX_PUSH && TX_FULL) viol++;
        if (ALU_EN && !CLK_GATE_EN) viol++;
        if (WR_EN)   obs_q.push_back(mk(EV_WR,  ADDRESS, {8'h00, WR_DATA}));
        if (RD_EN)   obs_q.push_back(mk(EV_RD,  ADDRESS, 16'h0000));
        if (ALU_EN)  obs_q.push_back(mk(EV_ALU, 4'h0,    {12'h000, ALU_FUN}));
        if (TX_PUSH) obs_q.push_back(mk(EV_TX,  4'h0,    {8'h00, TX_DATA}));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        cyc(1);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
    endtask

    // Bounded wait for the monitor to have recorded an event.
    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
        end
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        cyc(3);
        total++;
        if ({WR_EN, RD_EN, ALU_EN, TX_PUSH} !== 4'b0000)
            $display("FAIL reset_strobes: got %b expected 0000", {WR_EN, RD_EN, ALU_EN, TX_PUSH});
        else passed++;
        total++;
        if ({ADDRESS, WR_DATA, ALU_FUN, TX_DATA} !== 24'h0)
            $display("FAIL reset_data: got %h expected 000000", {ADDRESS, WR_DATA, ALU_FUN, TX_DATA});
        else passed++;
        total++;
        if (CLK_GATE_EN !== 1'b0)
            $display("FAIL reset_clk_gate: got %b expected 0", CLK_GATE_EN);
        else passed++;
        RST = 1'b0;
        cyc(1);
    endtask

    task automatic test_write;
        evt_t e, o;
        bit ok;
        exp_q.push_back(mk(EV_WR, 4'hC, 16'h00F0));
        send_byte(8'hAA); send_byte(8'h0C); send_byte(8'hF0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            total++;
            if (!ok) $display("FAIL write_evt: got timeout expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL write_evt: got %h expected %h", o, e);
                else passed++;
            end
        end
        cyc(6);
        total++;
        if (obs_q.size() != 0) $display("FAIL write_extra: got %0d extra events expected 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_read;
        evt_t e, o;
        bit ok;
        exp_q.push_back(mk(EV_RD, 4'hC, 16'h0000));
        exp_q.push_back(mk(EV_TX, 4'h0, 16'h00F0));
        send_byte(8'hBB); send_byte(8'h0C);
        cyc(1);
        send_byte(8'hAA);               // arrives in RD_WAIT, must be ignored
        RD_DATA = 8'hF0; RD_DATA_VLD = 1'b1;
        cyc(1);
        RD_DATA_VLD = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            total++;
            if (!ok) $display("FAIL read_evt: got timeout expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL read_evt: got %h expected %h", o, e);
                else passed++;
            end
        end
        // A stray command byte would have moved the FSM; feed address/data
        // bytes and expect nothing.
        send_byte(8'h03); send_byte(8'h44);
        cyc(6);
        total++;
        if (obs_q.size() != 0) $display("FAIL read_extra: got %0d extra events expected 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_alu_operands;
        evt_t e, o;
        bit ok;
        exp_q.push_back(mk(EV_WR,  4'h0, 16'h0005));
        exp_q.push_back(mk(EV_WR,  4'h1, 16'h0006));
        exp_q.push_back(mk(EV_ALU, 4'h0, 16'h0002));
        exp_q.push_back(mk(EV_TX,  4'h0, 16'h001E));
        exp_q.push_back(mk(EV_TX,  4'h0, 16'h0000));
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h06); send_byte(8'h02);
        @(negedge CLK);
        total++;
        if (CLK_GATE_EN !== 1'b1) $display("FAIL alu_gate_on: got %b expected 1", CLK_GATE_EN);
        else passed++;
        cyc(1);
        cyc(2);
        ALU_OUT = 16'h001E; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        total++;
        if (CLK_GATE_EN !== 1'b1) $display("FAIL alu_gate_capture: got %b expected 1", CLK_GATE_EN);
        else passed++;
        cyc(1);
        ALU_OUT_VLD = 1'b0;
        total++;
        if (CLK_GATE_EN !== 1'b0) $display("FAIL alu_gate_off: got %b expected 0", CLK_GATE_EN);
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            total++;
            if (!ok) $display("FAIL alu_evt: got timeout expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL alu_evt: got %h expected %h", o, e);
                else passed++;
            end
        end
        cyc(6);
        total++;
        if (obs_q.size() != 0) $display("FAIL alu_extra: got %0d extra events expected 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_tx_full;
        evt_t e, o;
        bit ok;
        exp_q.push_back(mk(EV_ALU, 4'h0, 16'h0000));
        exp_q.push_back(mk(EV_TX,  4'h0, 16'h0034));
        exp_q.push_back(mk(EV_TX,  4'h0, 16'h0012));
        send_byte(8'hDD); send_byte(8'h00);
        cyc(2);
        TX_FULL = 1'b1;
        ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
        cyc(1);
        ALU_OUT_VLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            total++;
            if (TX_PUSH !== 1'b0) $display("FAIL full_push_%0d: got %b expected 0", i, TX_PUSH);
            else passed++;
            total++;
            if (TX_DATA !== 8'h34) $display("FAIL full_data_%0d: got %h expected 34", i, TX_DATA);
            else passed++;
            @(posedge CLK); #1;
        end
        TX_FULL = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            total++;
            if (!ok) $display("FAIL full_evt: got timeout expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL full_evt: got %h expected %h", o, e);
                else passed++;
            end
        end
        cyc(6);
        total++;
        if (obs_q.size() != 0) $display("FAIL full_extra: got %0d extra events expected 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_junk_and_midreset;
        evt_t e, o;
        bit ok;
        send_byte(8'h55);
        cyc(5);
        total++;
        if (obs_q.size() != 0) $display("FAIL junk_byte: got %0d events expected 0", obs_q.size());
        else passed++;
        obs_q.delete();
        // Reach OP_B, then reset while the B byte is arriving.
        exp_q.push_back(mk(EV_WR, 4'h0, 16'h0005));
        send_byte(8'hCC); send_byte(8'h05);
        e = exp_q.pop_front();
        wait_obs(ok);
        total++;
        if (!ok) $display("FAIL midrst_opa: got timeout expected %h", e);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL midrst_opa: got %h expected %h", o, e);
            else passed++;
        end
        RST = 1'b1; RX_P_DATA = 8'h06; RX_D_VLD = 1'b1;
        cyc(1);
        RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0;
        total++;
        if ({ADDRESS, WR_EN, WR_DATA, RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_PUSH} !== 30'h0)
            $display("FAIL midrst_outputs: got %h expected 0",
                     {ADDRESS, WR_EN, WR_DATA, RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_PUSH});
        else passed++;
        send_byte(8'h02);               // would be func if OP_B survived; junk in IDLE
        cyc(5);
        total++;
        if (obs_q.size() != 0) $display("FAIL midrst_partial: got %0d events expected 0", obs_q.size());
        else passed++;
        obs_q.delete();
        exp_q.push_back(mk(EV_WR, 4'hC, 16'h00F0));
        send_byte(8'hAA); send_byte(8'h0C); send_byte(8'hF0);
        e = exp_q.pop_front();
        wait_obs(ok);
        total++;
        if (!ok) $display("FAIL midrst_write: got timeout expected %h", e);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL midrst_write: got %h expected %h", o, e);
            else passed++;
        end
        cyc(4);
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        evt_t e, o;
        bit ok;
        exp_q.push_back(mk(EV_WR, 4'h3, 16'h005A));
        exp_q.push_back(mk(EV_RD, 4'h3, 16'h0000));
        exp_q.push_back(mk(EV_TX, 4'h0, 16'h0077));
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5A);
        send_byte(8'hBB); send_byte(8'h03);
        RD_DATA = 8'h77; RD_DATA_VLD = 1'b1;
        cyc(1);
        RD_DATA_VLD = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            total++;
            if (!ok) $display("FAIL b2b_evt: got timeout expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL b2b_evt: got %h expected %h", o, e);
                else passed++;
            end
        end
        cyc(4);
        total++;
        if (viol != 0) $display("FAIL protocol_violations: got %0d expected 0", viol);
        else passed++;
    endtask

    initial begin
        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0;
        RD_DATA = '0; RD_DATA_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0; TX_FULL = 1'b0;
        @(posedge CLK); #1;
        test_reset;
        test_write;
        test_read;
        test_alu_operands;
        test_tx_full;
        test_junk_and_midreset;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
